// File: rtl/arm_mem_arb_pkg.sv
// Shared state encoding and constants for the ARM memory port arbiter.
package arm_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int         WCNT_W     = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/arm_mem_arb_if.sv
// Requester bus plus memory-port signals shared by the arbiter and its users.
interface arm_mem_arb_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_write;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_excpt;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, mem_excpt,
        output gnt, done, rdata, err,
        output mem_addr, mem_wdata, mem_write
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, mem_excpt,
        input  gnt, done, rdata, err,
        input  mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/arm_rr_picker.sv
// Combinational winner picker: round robin from ptr, or fixed priority
// (lowest index) when ARM_MEM_ARB_FIXED_PRIO_EN is defined.
module arm_rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_mask,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_win,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_any
);
    logic [NREQ-1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
`endif

    // Smallest distance from the pointer wins.
    always_comb begin
        int d;
        int best;
        d         = 0;
        best      = NREQ;
        o_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i + NREQ - int'(i_ptr)) % NREQ;
`endif
            if (w_elig[i] && d < best) begin
                best      = d;
                o_win_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |w_elig;
    assign o_win = o_any ? (NREQ'(1) << o_win_idx) : '0;

endmodule

// File: rtl/arm_mem_arbiter.sv
// Shares one ARM memory port among NREQ requesters with alignment/exception
// reporting. Define ARM_MEM_ARB_FIXED_PRIO_EN for fixed priority arbitration.
module arm_mem_arbiter
    import arm_mem_arb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input logic          i_clk,
    input logic          i_rst_n,
    arm_mem_arb_if.slave bus
);
    localparam int IDX_W = $clog2(NREQ);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic [IDX_W-1:0]  r_owner;
    logic              r_we;
    logic              r_mis;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WCNT_W-1:0] r_wcnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [NREQ-1:0]   w_owner_oh;
    logic [NREQ-1:0]   w_mask;
    logic [NREQ-1:0]   w_win;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_any;
    logic [IDX_W-1:0]  w_ptr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_grant;
    logic              w_last;
    logic [NREQ-1:0]   w_gnt;
    logic [NREQ-1:0]   w_done;
    logic              w_mem_write;

    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_mask     = (r_state == DONE) ? w_owner_oh : '0;
    assign w_sel_addr = bus.addr[w_win_idx*ADDR_W +: ADDR_W];

    arm_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req     (bus.req),
        .i_mask    (w_mask),
        .i_ptr     (w_ptr),
        .o_win     (w_win),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;

    assign w_ptr = r_rr_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (w_win_idx == IDX_W'(NREQ - 1)) ?
                        '0 : w_win_idx + IDX_W'(1);
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_last      = 1'b0;
        w_gnt       = '0;
        w_done      = '0;
        w_mem_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant = w_any;
                if (w_any) w_next = ACCESS;
            end
            ACCESS: begin
                w_gnt       = w_owner_oh;
                w_last      = (r_wcnt == '0);
                // Misaligned writes never reach memory.
                w_mem_write = w_last & r_we & ~r_mis;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_done  = w_owner_oh;
                w_grant = w_any;
                w_next  = w_any ? ACCESS : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner <= w_win_idx;
                r_we    <= bus.we[w_win_idx];
                r_mis   <= is_misaligned(w_sel_addr[1:0]);
                r_addr  <= w_sel_addr;
                r_wdata <= bus.wdata[w_win_idx*DATA_W +: DATA_W];
                r_wcnt  <= WCNT_W'(WAIT_CYCLES);
            end else if (r_state == ACCESS && !w_last) begin
                r_wcnt <= r_wcnt - WCNT_W'(1);
            end
            if (w_last) begin
                if (!r_we && !r_mis) r_rdata <= bus.mem_rdata;
                r_err <= r_mis | bus.mem_excpt;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.done      = w_done;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_write = w_mem_write;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Randomized bench for arm_mem_arbiter against a transaction-schedule model
// and a shadow memory; directed cases cover read, write, contention, errors, reset.
module tb_arm_mem_arbiter;
    localparam int NREQ = 3;
    localparam int WAIT = 1;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam logic [DW-1:0] UNMAPPED_DATA = 32'hDEAD_DEAD;

    logic clk;
    logic rst_n;

    arm_mem_arb_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    arm_mem_arbiter #(
        .NREQ        (NREQ),
        .WAIT_CYCLES (WAIT),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory environment: two mapped windows, everything >= 2MB raises excpt.
    logic [DW-1:0] mem    [128];
    logic [DW-1:0] shadow [128];
    int            wr_cnt = 0;

    function automatic logic mapped(input logic [AW-1:0] a);
        return a < 32'h0020_0000;
    endfunction

    function automatic int widx(input logic [AW-1:0] a);
        return int'({a[20], a[7:2]});
    endfunction

    assign bus.mem_rdata = mapped(bus.mem_addr) ?
                           mem[widx(bus.mem_addr)] : UNMAPPED_DATA;
    assign bus.mem_excpt = !mapped(bus.mem_addr);

    // Requester side
    logic [NREQ-1:0] p_act = '0;
    logic [NREQ-1:0] p_we  = '0;
    logic [AW-1:0]   p_addr  [NREQ];
    logic [DW-1:0]   p_wdata [NREQ];

    // Schedule model: an access decided before edge k owns the port for
    // edges k..k+WAIT, completes at k+WAIT+1, and the next decision can be
    // made before edge k+WAIT+2 (previous owner excluded there only).
    int            cyc      = 0;
    int            nfree    = 0;
    int            prev_own = -1;
    int            m_ptr    = 0;
    int            a_own    = -1;
    int            a_start  = 0;
    int            a_done   = 0;
    int            wr_snap  = 0;
    logic          a_we     = 1'b0;
    logic [AW-1:0] a_addr   = '0;
    logic [DW-1:0] a_wdata  = '0;
    logic [DW-1:0] e_rdata  = '0;
    logic          e_err    = 1'b0;

    task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        p_act[i]   = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic drive();
        bus.req = p_act;
        bus.we  = p_we;
        for (int i = 0; i < NREQ; i++) begin
            bus.addr[i*AW +: AW]  = p_addr[i];
            bus.wdata[i*DW +: DW] = p_wdata[i];
        end
    endtask

    task automatic decide();
        int k;
        int w;
        int mask;
        int i;
        k = cyc + 1;
        if (k < nfree) return;
        mask = (k == nfree) ? prev_own : -1;
        w = -1;
        for (int n = 0; n < NREQ; n++) begin
`ifdef ARM_MEM_ARB_FIXED_PRIO_EN
            i = n;
`else
            i = (m_ptr + n) % NREQ;
`endif
            if (w < 0 && p_act[i] && i != mask) w = i;
        end
        if (w < 0) return;
        a_own    = w;
        a_start  = k;
        a_done   = k + WAIT + 1;
        nfree    = a_done + 1;
        prev_own = w;
        m_ptr    = (w + 1) % NREQ;
        a_we     = p_we[w];
        a_addr   = p_addr[w];
        a_wdata  = p_wdata[w];
        wr_snap  = wr_cnt;
    endtask

    task automatic observe();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ed;
        logic            mis;
        logic            mp;
        eg = '0;
        ed = '0;
        if (a_own >= 0 && cyc >= a_start && cyc < a_done) eg[a_own] = 1'b1;
        if (a_own >= 0 && cyc == a_done) ed[a_own] = 1'b1;
        chk("gnt", 64'(bus.gnt), 64'(eg));
        chk("done", 64'(bus.done), 64'(ed));
        if (eg != '0) chk("mem_addr", 64'(bus.mem_addr), 64'(a_addr));
        if (ed != '0) begin
            mis   = a_addr[1:0] != 2'b00;
            mp    = mapped(a_addr);
            e_err = mis || !mp;
            if (!a_we && !mis) e_rdata = mp ? shadow[widx(a_addr)] : UNMAPPED_DATA;
            if (a_we && !mis && mp) shadow[widx(a_addr)] = a_wdata;
            chk("writes", 64'(wr_cnt - wr_snap), 64'(a_we && !mis));
            p_act[a_own] = 1'b0;
        end
        chk("rdata", 64'(bus.rdata), 64'(e_rdata));
        chk("err", 64'(bus.err), 64'(e_err));
    endtask

    task automatic tick();
        logic          mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        drive();
        decide();
        @(negedge clk);
        mw = bus.mem_write;
        ma = bus.mem_addr;
        md = bus.mem_wdata;
        @(posedge clk);
        if (mw) begin
            wr_cnt++;
            if (mapped(ma)) mem[widx(ma)] = md;
        end
        cyc++;
        #1;
        observe();
    endtask

    task automatic run_idle(input int max);
        int g;
        g = 0;
        while ((p_act != '0 || (a_own >= 0 && cyc < a_done)) && g < max) begin
            tick();
            g++;
        end
        if (g >= max) chk("timeout", 64'(p_act), 64'(0));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] base;
        logic [AW-1:0] word;
        int            r;
        r    = $urandom_range(0, 9);
        base = $urandom_range(0, 1) ? 32'h0010_0000 : 32'h0;
        word = AW'($urandom_range(0, 63)) << 2;
        if (r == 0) return base + word + AW'($urandom_range(1, 3));
        if (r == 1) return 32'h0020_0000 + word;
        return base + word;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_mwr"}, 64'(bus.mem_write), 64'(0));
        chk({tag, "_maddr"}, 64'(bus.mem_addr), 64'(0));
        chk({tag, "_mwdata"}, 64'(bus.mem_wdata), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(0));
        chk({tag, "_err"}, 64'(bus.err), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int            g;
        for (int i = 0; i < 128; i++) begin
            v         = $urandom();
            mem[i]    = v;
            shadow[i] = v;
        end
        mem[widx(32'h10)]    = 32'hDEAD_BEEF;
        shadow[widx(32'h10)] = 32'hDEAD_BEEF;
        for (int i = 0; i < NREQ; i++) begin
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
        drive();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single read
        issue(0, 1'b0, 32'h10, '0);
        run_idle(20);
        chk("t1_rdata", 64'(bus.rdata), 64'(32'hDEAD_BEEF));

        // write then readback
        issue(1, 1'b1, 32'h0010_0004, 32'h1234_5678);
        run_idle(20);
        issue(0, 1'b0, 32'h0010_0004, '0);
        run_idle(20);
        chk("t2_rdata", 64'(bus.rdata), 64'(32'h1234_5678));

        // contention
        for (int i = 0; i < NREQ; i++) issue(i, 1'b0, 32'h40 + AW'(4 * i), '0);
        run_idle(40);

        // misaligned write
        issue(2, 1'b1, 32'h13, 32'hFFFF_FFFF);
        run_idle(20);
        chk("t4_err", 64'(bus.err), 64'(1));

        // memory exception, then a clean access
        issue(1, 1'b0, 32'h0020_0000, '0);
        run_idle(20);
        chk("t5_err", 64'(bus.err), 64'(1));
        issue(1, 1'b0, 32'h14, '0);
        run_idle(20);
        chk("t5_err_clr", 64'(bus.err), 64'(0));

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_act[i] && $urandom_range(0, 3) == 0)
                    issue(i, 1'(($urandom_range(0, 1))), rand_addr(), $urandom());
            tick();
        end
        run_idle(100);
        repeat (2) tick();

        // reset during the first ACCESS cycle of a write
        issue(1, 1'b1, 32'h20, 32'hCAFE_F00D);
        g = 0;
        while (!(a_own == 1 && cyc == a_start) && g < 10) begin
            tick();
            g++;
        end
        chk("t6_gnt_pre", 64'(bus.gnt), 64'(3'b010));
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        a_own    = -1;
        nfree    = 0;
        prev_own = -1;
        m_ptr    = 0;
        e_rdata  = '0;
        e_err    = 1'b0;
        p_act    = '0;
        drive();
        @(posedge clk);
        cyc++;
        #1;
        chk("t6_rst_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        issue(2, 1'b1, 32'h24, 32'h5555_AAAA);
        issue(0, 1'b0, 32'h20, '0);
        tick();
        chk("t6_first_gnt", 64'(bus.gnt), 64'(3'b001));
        run_idle(40);

        for (int i = 0; i < 128; i++) chk("mem_final", 64'(mem[i]), 64'(shadow[i]));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
